// File: rtl/uart_imem_loader.sv
// Boot loader: receives a framed 8N1 UART image, writes it to IMEM port A, releases the core on a good checksum.
// Latency: one mem_we cycle the clock after each word's 4th byte is received; core_rst_n rises the clock after CHK is received.
// Backpressure: none; the memory port must accept every write, and bytes arriving after DONE are dropped.
module uart_imem_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          MAX_WORDS    = 2048,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic [3:0]  mem_we,
    output logic [12:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        core_rst_n,
    output logic        busy,
    output logic        error
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int IW = $clog2(MAX_WORDS + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA, CHK, DONE, ERROR} st_t;

    logic            rx_s1, rx_s2, rx_s3;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_sh;
    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic            frame_err;

    // rx_s3 is only an edge-detect delay; it keeps a low stop bit from looking like a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_s3      <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_s1      <= uart_rx;
            rx_s2      <= rx_s1;
            rx_s3      <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_s3 && !rx_s2)
                        rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_M1) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_s2, rx_sh[7:1]};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == FULL_M1) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_sh;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    st_t         st;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [IW-1:0] widx;
    logic [1:0]  bcnt;
    logic [31:0] asm_word;
    logic [7:0]  csum;
    logic [15:0] len_rx;

    assign len_rx = {rx_byte, len_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= WAIT_SYNC;
            len_lo     <= '0;
            len        <= '0;
            widx       <= '0;
            bcnt       <= '0;
            asm_word   <= '0;
            csum       <= '0;
            mem_we     <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= '0;
            if (frame_err) begin
                if (st inside {LEN_LO, LEN_HI, DATA, CHK}) begin
                    st    <= ERROR;
                    busy  <= 1'b0;
                    error <= 1'b1;
                end
            end else if (byte_valid) begin
                case (st)
                    WAIT_SYNC, ERROR: begin
                        if (rx_byte == SYNC_BYTE) begin
                            st    <= LEN_LO;
                            busy  <= 1'b1;
                            error <= 1'b0;
                            csum  <= '0;
                            widx  <= '0;
                            bcnt  <= '0;
                        end
                    end
                    LEN_LO: begin
                        len_lo <= rx_byte;
                        st     <= LEN_HI;
                    end
                    LEN_HI: begin
                        len <= len_rx;
                        if (len_rx > 16'(MAX_WORDS)) begin
                            st    <= ERROR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else if (len_rx == 16'd0) begin
                            st <= CHK;
                        end else begin
                            st <= DATA;
                        end
                    end
                    DATA: begin
                        csum     <= csum + rx_byte;
                        asm_word <= {rx_byte, asm_word[31:8]};
                        bcnt     <= bcnt + 1'b1;
                        if (bcnt == 2'd3) begin
                            mem_we   <= 4'hF;
                            mem_din  <= {rx_byte, asm_word[31:8]};
                            mem_addr <= 13'({widx, 2'b00});
                            widx     <= widx + 1'b1;
                            if (16'(widx) == len - 16'd1)
                                st <= CHK;
                        end
                    end
                    CHK: begin
                        busy <= 1'b0;
                        if (rx_byte == csum) begin
                            st         <= DONE;
                            core_rst_n <= 1'b1;
                        end else begin
                            st    <= ERROR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed bench for uart_imem_loader at CLKS_PER_BIT=4: bit-level UART driver plus a write monitor.
module tb_uart_imem_loader;
    localparam int CLKS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx = 1'b1;
    logic [3:0]  mem_we;
    logic [12:0] mem_addr;
    logic [31:0] mem_din;
    logic        core_rst_n;
    logic        busy;
    logic        error;

    int checks = 0;
    int failures = 0;

    logic [7:0]  tx_q[$];
    logic [3:0]  wq_we[$];
    logic [12:0] wq_addr[$];
    logic [31:0] wq_din[$];

    uart_imem_loader #(.CLKS_PER_BIT(CLKS), .MAX_WORDS(2048), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .core_rst_n(core_rst_n), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we !== 4'h0) begin
            wq_we.push_back(mem_we);
            wq_addr.push_back(mem_addr);
            wq_din.push_back(mem_din);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rx = 1'b0;
        idle(CLKS);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(CLKS);
        end
        uart_rx = stop_bit;
        idle(CLKS);
        uart_rx = 1'b1;
        idle(2 * CLKS);
    endtask

    task automatic send_q();
        for (int i = 0; i < tx_q.size(); i++)
            send_byte(tx_q[i], 1'b1);
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        uart_rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        wq_we.delete(); wq_addr.delete(); wq_din.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        checks++; if (mem_we !== 4'h0) begin failures++; $display("FAIL reset_we got=%h exp=0", mem_we); end
        checks++; if (mem_addr !== 13'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_din !== 32'h0) begin failures++; $display("FAIL reset_din got=%h exp=0", mem_din); end
        checks++; if (core_rst_n !== 1'b0) begin failures++; $display("FAIL reset_core got=%b exp=0", core_rst_n); end
        checks++; if (busy !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%b error=%b exp=0/0", busy, error); end
        do_reset();
    endtask

    task automatic test_basic();
        do_reset();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_q();
        checks++; if (busy !== 1'b1 || core_rst_n !== 1'b0) begin failures++; $display("FAIL basic_prechk busy=%b core=%b exp=1/0", busy, core_rst_n); end
        send_byte(8'hB6, 1'b1);
        idle(4);
        checks++; if (wq_we.size() !== 2) begin failures++; $display("FAIL basic_nwr got=%0d exp=2", wq_we.size()); end
        if (wq_we.size() >= 2) begin
            checks++; if (wq_we[0] !== 4'hF || wq_we[1] !== 4'hF) begin failures++; $display("FAIL basic_we got=%h,%h exp=F,F", wq_we[0], wq_we[1]); end
            checks++; if (wq_addr[0] !== 13'h000 || wq_din[0] !== 32'h00000013) begin failures++; $display("FAIL basic_w0 got=%h:%h exp=000:00000013", wq_addr[0], wq_din[0]); end
            checks++; if (wq_addr[1] !== 13'h004 || wq_din[1] !== 32'h00100093) begin failures++; $display("FAIL basic_w1 got=%h:%h exp=004:00100093", wq_addr[1], wq_din[1]); end
        end
        checks++; if (core_rst_n !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_done core=%b err=%b busy=%b exp=1/0/0", core_rst_n, error, busy); end
        // Frames after DONE must be ignored entirely.
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
        send_q();
        checks++; if (wq_we.size() !== 2 || core_rst_n !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL done_ignore nwr=%0d core=%b busy=%b exp=2/1/0", wq_we.size(), core_rst_n, busy); end
    endtask

    task automatic test_bad_chk();
        do_reset();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        send_q();
        checks++; if (wq_we.size() !== 2) begin failures++; $display("FAIL badchk_nwr got=%0d exp=2", wq_we.size()); end
        checks++; if (error !== 1'b1 || core_rst_n !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL badchk_flags err=%b core=%b busy=%b exp=1/0/0", error, core_rst_n, busy); end
        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
        send_q();
        checks++; if (error !== 1'b0 || core_rst_n !== 1'b1) begin failures++; $display("FAIL badchk_recover err=%b core=%b exp=0/1", error, core_rst_n); end
        checks++; if (wq_we.size() !== 2) begin failures++; $display("FAIL badchk_recover_nwr got=%0d exp=2", wq_we.size()); end
    endtask

    task automatic test_leading();
        do_reset();
        tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        send_q();
        checks++; if (wq_we.size() !== 1) begin failures++; $display("FAIL lead_nwr got=%0d exp=1", wq_we.size()); end
        if (wq_we.size() >= 1) begin
            checks++; if (wq_addr[0] !== 13'h0 || wq_din[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL lead_w0 got=%h:%h exp=000:deadbeef", wq_addr[0], wq_din[0]); end
        end
        checks++; if (core_rst_n !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL lead_done core=%b err=%b exp=1/0", core_rst_n, error); end
    endtask

    task automatic test_len_err();
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h08};
        send_q();
        checks++; if (error !== 1'b1 || busy !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL len_err err=%b busy=%b core=%b exp=1/0/0", error, busy, core_rst_n); end
        tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_q();
        checks++; if (wq_we.size() !== 0) begin failures++; $display("FAIL len_nwr got=%0d exp=0", wq_we.size()); end
        // Exactly MAX_WORDS is accepted: loader stays busy in DATA.
        tx_q = '{8'hA5, 8'h00, 8'h08, 8'h11};
        send_q();
        checks++; if (error !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL len_max err=%b busy=%b exp=0/1", error, busy); end
    endtask

    task automatic test_stop_err();
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
        send_q();
        send_byte(8'h22, 1'b0);
        tx_q = '{8'h33, 8'h44};
        send_q();
        checks++; if (error !== 1'b1 || busy !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL stop_err err=%b busy=%b core=%b exp=1/0/0", error, busy, core_rst_n); end
        checks++; if (wq_we.size() !== 0) begin failures++; $display("FAIL stop_nwr got=%0d exp=0", wq_we.size()); end
    endtask

    task automatic test_glitch();
        do_reset();
        tx_q = '{8'hA5, 8'h01, 8'h00};
        send_q();
        uart_rx = 1'b0; idle(1); uart_rx = 1'b1; idle(3 * CLKS);
        uart_rx = 1'b0; idle(1); uart_rx = 1'b1; idle(3 * CLKS);
        tx_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h14};
        send_q();
        checks++; if (wq_we.size() !== 1) begin failures++; $display("FAIL glitch_nwr got=%0d exp=1", wq_we.size()); end
        if (wq_we.size() >= 1) begin
            checks++; if (wq_din[0] !== 32'h12345678) begin failures++; $display("FAIL glitch_w0 got=%h exp=12345678", wq_din[0]); end
        end
        checks++; if (core_rst_n !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL glitch_done core=%b err=%b exp=1/0", core_rst_n, error); end
    endtask

    task automatic test_back_to_back_reset();
        do_reset();
        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33};
        send_q();
        checks++; if (busy !== 1'b1 || mem_din !== 32'h04030201) begin failures++; $display("FAIL midrst_pre busy=%b din=%h exp=1/04030201", busy, mem_din); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_we !== 4'h0 || mem_addr !== 13'h0 || mem_din !== 32'h0) begin failures++; $display("FAIL midrst_mem we=%h addr=%h din=%h exp=0/0/0", mem_we, mem_addr, mem_din); end
        checks++; if (busy !== 1'b0 || error !== 1'b0 || core_rst_n !== 1'b0) begin failures++; $display("FAIL midrst_flags busy=%b err=%b core=%b exp=0/0/0", busy, error, core_rst_n); end
        idle(2);
        rst_n = 1'b1;
        idle(3);
        wq_we.delete(); wq_addr.delete(); wq_din.delete();
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        send_q();
        checks++; if (wq_we.size() !== 1) begin failures++; $display("FAIL midrst_nwr got=%0d exp=1", wq_we.size()); end
        if (wq_we.size() >= 1) begin
            checks++; if (wq_addr[0] !== 13'h0 || wq_din[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL midrst_w0 got=%h:%h exp=000:deadbeef", wq_addr[0], wq_din[0]); end
        end
        checks++; if (core_rst_n !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL midrst_done core=%b err=%b exp=1/0", core_rst_n, error); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_chk();
        test_leading();
        test_len_err();
        test_stop_err();
        test_glitch();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
